re_log_mul_pipe: RTL and testbench

- Pipelined Mitchell logarithmic approximate multiplier for two unsigned `NUM_LENGTH`-bit (32) operands.
- Consumes the `K_LENGTH`-bit (5) leading-one positions from two internal lod32 instances.
- Builds the log-domain operands, adds them, and anti-logs the sum back to a 64-bit product.
- Sits downstream of the leading-one detectors and feeds the result collector over a valid/ready handshake.

---
 rtl/re_log_mul_pipe_if.sv | 29 ++
 rtl/re_log_mul_pipe.sv | 130 +++++++++++++
 tb/tb_re_log_mul_pipe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/re_log_mul_pipe_if.sv
// Operand/product handshake bundle for re_log_mul_pipe.
// Operand width comes from `NUM_LENGTH (default 32).
`ifndef NUM_LENGTH
`define NUM_LENGTH 32
`endif
`ifndef K_LENGTH
`define K_LENGTH 5
`endif

interface re_log_mul_pipe_if;
  logic                     in_valid;
  logic                     in_ready;
  logic [`NUM_LENGTH-1:0]   in_a;
  logic [`NUM_LENGTH-1:0]   in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [63:0]              out_prod;
  logic                     out_zero;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, out_zero
  );
endinterface

// File: rtl/re_log_mul_pipe.sv
// Three-stage Mitchell log multiplier: leading-one/fraction, log add, anti-log shift.
// Define RE_LOG_MUL_COMP_EN to add the no-carry bias correction in the log-add stage.
`ifndef NUM_LENGTH
`define NUM_LENGTH 32
`endif
`ifndef K_LENGTH
`define K_LENGTH 5
`endif

module re_log_mul_pipe #(
  parameter int unsigned FRAC_W = 16
) (
  input logic              clk,
  input logic              rst,
  re_log_mul_pipe_if.slave bus
);
  localparam int unsigned N  = `NUM_LENGTH;
  localparam int unsigned K  = `K_LENGTH;
  localparam int unsigned LW = FRAC_W + K + 1;

  function automatic logic [K-1:0] lod32(input logic [N-1:0] x);
    logic [K-1:0] pos;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) pos = K'(i);
    end
    return pos;
  endfunction

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage 1: leading-one position and left-aligned fraction below it
  logic [K-1:0]      ka_d, kb_d;
  logic [N-1:0]      sha, shb;
  logic [FRAC_W-1:0] fa_d, fb_d;
  logic              unused_sh;

  always_comb begin
    ka_d = lod32(bus.in_a);
    kb_d = lod32(bus.in_b);
    sha  = bus.in_a << (K'(N - 1) - ka_d);
    shb  = bus.in_b << (K'(N - 1) - kb_d);
    fa_d = sha[N-2 -: FRAC_W];
    fb_d = shb[N-2 -: FRAC_W];
  end
  assign unused_sh = ^{sha, shb};

  logic              s1_valid, s1_zero;
  logic [K-1:0]      s1_ka, s1_kb;
  logic [FRAC_W-1:0] s1_fa, s1_fb;

  // Stage 2: log-domain add
  logic [LW-1:0]     lsum;
  logic [K:0]        ksum_d;
  logic [FRAC_W-1:0] fsum_d;
`ifdef RE_LOG_MUL_COMP_EN
  localparam logic [FRAC_W:0] CompInc = {4'b0000, 1'b1, {(FRAC_W-4){1'b0}}};
  logic              lcarry;
  logic [FRAC_W:0]   fcomp;
`endif

  always_comb begin
    lsum   = {1'b0, s1_ka, s1_fa} + {1'b0, s1_kb, s1_fb};
    ksum_d = lsum[LW-1:FRAC_W];
    fsum_d = lsum[FRAC_W-1:0];
`ifdef RE_LOG_MUL_COMP_EN
    // Bit FRAC_W of the sum is ka[0]^kb[0]^carry, so the fraction carry falls out for free.
    lcarry = lsum[FRAC_W] ^ s1_ka[0] ^ s1_kb[0];
    fcomp  = {1'b0, fsum_d} + CompInc;
    if (!lcarry) fsum_d = fcomp[FRAC_W] ? '1 : fcomp[FRAC_W-1:0];
`endif
  end

  logic              s2_valid, s2_zero;
  logic [K:0]        s2_ksum;
  logic [FRAC_W-1:0] s2_fsum;

  // Stage 3: anti-log, 1.fsum scaled by 2^ksum
  logic [63+FRAC_W:0] mext, mshift;
  logic [63:0]        prod_d;
  logic               unused_mshift;

  always_comb begin
    mext   = {{63{1'b0}}, 1'b1, s2_fsum};
    mshift = mext << s2_ksum;
    prod_d = mshift[63+FRAC_W:FRAC_W];
  end
  assign unused_mshift = ^mshift;

  logic        out_valid_q, out_zero_q;
  logic [63:0] out_prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_zero     <= 1'b0;
      s1_ka       <= '0;
      s1_kb       <= '0;
      s1_fa       <= '0;
      s1_fb       <= '0;
      s2_valid    <= 1'b0;
      s2_zero     <= 1'b0;
      s2_ksum     <= '0;
      s2_fsum     <= '0;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_prod_q  <= '0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      s1_zero     <= (bus.in_a == '0) || (bus.in_b == '0);
      s1_ka       <= ka_d;
      s1_kb       <= kb_d;
      s1_fa       <= fa_d;
      s1_fb       <= fb_d;
      s2_valid    <= s1_valid;
      s2_zero     <= s1_zero;
      s2_ksum     <= ksum_d;
      s2_fsum     <= fsum_d;
      out_valid_q <= s2_valid;
      out_zero_q  <= s2_zero;
      out_prod_q  <= s2_zero ? '0 : prod_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_prod  = out_prod_q;
endmodule

// File: tb/tb_re_log_mul_pipe.sv
// Self-checking bench for re_log_mul_pipe: directed table, stall, random stream, mid-flight reset.
`timescale 1ns/1ps
module tb_re_log_mul_pipe;
  localparam int unsigned F = 16;
`ifdef RE_LOG_MUL_COMP_EN
  localparam bit Comp = 1'b1;
`else
  localparam bit Comp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  re_log_mul_pipe_if bus ();

  re_log_mul_pipe #(.FRAC_W(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        zero;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [64:0] q[$];
  bit          hold_chk = 1'b0;
  logic [63:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: log2 as integer part + truncated binary fraction, then 2^ks * (1 + fs/2^F).
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ka, kb, fa, fb, ks, fs, one;
    logic [127:0] p;
    if (a == 0 || b == 0) return {1'b1, 64'd0};
    ka = 0;
    while ((64'(a) >> (ka + 1)) != 0) ka++;
    kb = 0;
    while ((64'(b) >> (kb + 1)) != 0) kb++;
    one = 64'd1 << F;
    fa = ((64'(a) - (64'd1 << ka)) << F) >> ka;
    fb = ((64'(b) - (64'd1 << kb)) << F) >> kb;
    ks = ka + kb;
    fs = fa + fb;
    if (fs >= one) begin
      ks++;
      fs -= one;
    end else if (Comp) begin
      fs += one >> 4;
      if (fs > one - 1) fs = one - 1;
    end
    p = (128'(one) + 128'(fs)) << ks;
    p = p >> F;
    return {1'b0, p[63:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h1 << $urandom_range(0, 31);
      2:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive at posedge+1, sample at negedge, return at next posedge+1.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input bit rdy,
                      output bit acc);
    logic [64:0] e;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = rdy;
    @(negedge clk);
    if (hold_chk) begin
      chk("hold valid", 64'(bus.out_valid), 64'd1);
      chk("hold prod", bus.out_prod, held);
    end
    if (bus.out_valid && !rdy) chk("stall in_ready", 64'(bus.in_ready), 64'd0);
    acc = v && bus.in_ready;
    if (acc) q.push_back(model(a, b));
    if (bus.out_valid && rdy) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected output", 64'(bus.out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("stream prod", bus.out_prod, e[63:0]);
        chk("stream zero", 64'(bus.out_zero), 64'(e[64]));
      end
    end
    hold_chk = bus.out_valid && !rdy;
    held     = bus.out_prod;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 32'd0, 32'd0, 1'b1, acc);
    chk("drain empty", 64'(q.size()), 64'd0);
  endtask

  task automatic run_one(input vec_t v, input string name);
    int lat;
    bus.in_valid  = 1'b1;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'd3);
    chk({name, " prod"}, bus.out_prod, v.prod);
    chk({name, " zero"}, 64'(bus.out_zero), 64'(v.zero));
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  vec_t v;
  bit   acc;
  int   sent, base;
  logic [31:0] sa[6], sb[6];

  initial begin
    vecs[0] = '{32'd3, 32'd5, 64'd14, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0001_0000,
                Comp ? 64'h1_1000_0000 : 64'h1_0000_0000, 1'b0};
    vecs[2] = '{32'd1, 32'd1, 64'd1, 1'b0};
    vecs[3] = '{32'd0, 32'hDEAD_BEEF, 64'd0, 1'b1};
    vecs[4] = '{32'd5, 32'd5, Comp ? 64'd25 : 64'd24, 1'b0};
    vecs[5] = '{32'd3, 32'd3, 64'd8, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_0000_0000_0000, 1'b0};
    vecs[7] = '{32'd1, 32'h8000_0000, Comp ? 64'h8800_0000 : 64'h8000_0000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_prod", bus.out_prod, 64'd0);
    chk("reset out_zero", 64'(bus.out_zero), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Six back-to-back pairs with out_ready dropped for four cycles
    for (int i = 0; i < 6; i++) begin
      sa[i] = rnd_op();
      sb[i] = rnd_op();
    end
    base = n_out;
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      step(sent < 6, sa[sent % 6], sb[sent % 6], !(c >= 4 && c < 8), acc);
      if (acc) sent++;
    end
    drain();
    chk("stall sent", 64'(sent), 64'd6);
    chk("stall delivered", 64'(n_out - base), 64'd6);

    // Randomized valid/ready stream against the reference model
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), $urandom_range(0, 3) != 0, acc);
    drain();

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) step(1'b1, rnd_op(), rnd_op(), 1'b1, acc);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset out_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    hold_chk = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    v = '{32'd7, 32'd9, Comp ? 64'd62 : 64'd60, 1'b0};
    run_one(v, "post_reset");
    repeat (3) begin
      @(negedge clk);
      chk("idle out_valid", 64'(bus.out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
